fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//  Read-side consumer for the FIFO block, in the same clock domain as its read port.
//  - Drives the FIFO's rd_en and captures the same-cycle data_rd.
//  - Re-presents that data as a registered valid/ready stream with a 2-entry buffer, so full
//    throughput needs no combinational path from m_ready to fifo_rd_en.
//  - Frames the stream into fixed-length packets with m_last.
// PARAMETERS
//  DATA_WIDTH  8   word width; equals the FIFO DATA_WIDTH
//  PKT_LEN     4   beats per packet, >=1; m_last marks the final beat
// PORTS
//  clk           in   1           single clock; connects to the FIFO rd_clk
//  rst           in   1           asynchronous reset, active-high
//  fifo_empty    in   1           FIFO empty flag
//  fifo_rd_en    out  1           FIFO read strobe (combinational)
//  fifo_data_rd  in   DATA_WIDTH  FIFO data_rd; valid in the same cycle as fifo_rd_en & !fifo_empty
//  clr           in   1           synchronous flush of buffer and beat counter
//  m_valid       out  1           output word valid (registered)
//  m_ready       in   1           downstream accept
//  m_data        out  DATA_WIDTH  output word (registered)
//  m_last        out  1           last beat of packet (registered)
//  level         out  2           words held in buffer, 0..2
// BEHAVIOUR
//  Reset (async, rst=1): all outputs are zero.
//   - level=0, m_valid=0, m_data=0, m_last=0, beat counter=0; both buffer slots are zeroed.
//  Buffer structure: slot0 feeds m_data; slot1 is the skid slot; level is the registered count.
//   - m_valid = (level != 0).
//  Read strobe: fifo_rd_en = !fifo_empty & (level != 2) & !clr & !rst.
//   - m_ready is not used in this expression.
//  Push: when fifo_rd_en is high, fifo_data_rd is written into the buffer at that clk edge.
//  Pop: m_valid & m_ready; slot0 is consumed and slot1, if occupied, shifts into slot0.
//  Simultaneous push and pop:
//   - At level=1, level stays 1 and slot0 takes the new word.
//   - Level=2 cannot push, so no push/pop conflict exists there.
//  Level update: level_next = level + push - pop.
//  Ordering: strict FIFO order; no word is dropped or duplicated.
//  Throughput and latency:
//   - Sustained 1 word/clk when FIFO is non-empty and m_ready=1.
//   - Latency 1 clk from the rd_en cycle to m_valid.
//  Backpressure: with m_ready=0, at most 2 further words are read, then fifo_rd_en stays 0.
//   - m_data and m_last hold stable while m_valid & !m_ready.
//  Beat counter: width clogb2(PKT_LEN), counts 0..PKT_LEN-1.
//   - Increments on each pop; wraps to 0 after PKT_LEN-1.
//  m_last: m_last = m_valid & (beat_cnt == PKT_LEN-1).
//   - PKT_LEN=1 gives m_last=m_valid on every beat.
//  clr=1 (synchronous): next edge sets level=0 and beat_cnt=0.
//   - Buffered words are discarded; no FIFO read occurs that cycle.
//   - A pop in the clr cycle is still a valid transfer downstream.
//  Reset mid-operation: buffer contents and the partial-packet count are lost immediately.
//   - fifo_rd_en is forced 0 while rst=1.
// TESTING
//  1. Reset: assert rst with level=2 -> m_valid=0, m_data=0, m_last=0, level=0, fifo_rd_en=0 at once.
//  2. Single word: FIFO holds 0xA5, m_ready=1 -> rd_en pulses 1 clk; next clk m_valid=1, m_data=0xA5; then level=0.
//  3. Streaming: 8 words 0x01..0x08 with m_ready=1 -> m_valid high 8 consecutive clks, data in order, level stays 1.
//  4. Backpressure: 5 words queued, m_ready=0 for 10 clks -> exactly 2 reads, level=2, m_data=0x01 stable; release -> 0x01..0x05 in order.
//  5. Framing, PKT_LEN=4: 8 beats with random m_ready -> m_last only on beats 4 and 8; no m_last on stalled cycles.
//  6. clr after 2 beats of a packet: level=0 next clk; the next popped beat restarts at 1, m_last on the 4th beat after clr.

Source files
------------

// File: rtl/fifo_stream_reader_if.sv
// Stream-reader bus: FIFO read port on one side, registered valid/ready
// packet stream on the other. master = the reader, slave = its environment.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data_rd;
  logic                  clr;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic [1:0]            level;

  modport master (
    input  fifo_empty, fifo_data_rd, clr, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last, level
  );

  modport slave (
    output fifo_empty, fifo_data_rd, clr, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last, level
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// FIFO read-side consumer. Reads the FIFO whenever the 2-entry buffer has
// room, so the read strobe never depends on m_ready; slot0 drives the
// output stream, slot1 is the skid slot. A beat counter frames the stream
// into PKT_LEN-beat packets marked by m_last.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input logic                 clk,
  input logic                 rst,
  fifo_stream_reader_if.master bus
);
  localparam int            CW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

  logic [1:0]            level;
  logic [DATA_WIDTH-1:0] slot0, slot1;
  logic [CW-1:0]         beat_cnt;
  logic                  push, pop;

  // Read whenever there is room; rst and clr block the read combinationally.
  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    push = !bus.fifo_empty && (level != 2'd2) && !bus.clr && !rst;
    pop  = (level != 2'd0) && bus.m_ready;
  end

  assign bus.fifo_rd_en = push;
  assign bus.m_valid    = (level != 2'd0);
  assign bus.m_data     = slot0;
  assign bus.m_last     = (level != 2'd0) && (beat_cnt == LAST_BEAT);
  assign bus.level      = level;

  // Buffer slots and occupancy; clr drops the contents but a pop in that
  // cycle has already been seen downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (bus.clr) begin
      level <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (level == 2'd0) slot0 <= bus.fifo_data_rd;
          else               slot1 <= bus.fifo_data_rd;
          level <= level + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          level <= level - 2'd1;
        end
        // Only reachable at level 1: the new word replaces the popped one.
        2'b11: slot0 <= bus.fifo_data_rd;
        default: ;
      endcase
    end
  end

  // Beat position within the current packet, advanced per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                beat_cnt <= '0;
    else if (bus.clr)       beat_cnt <= '0;
    else if (pop) begin
      if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
      else                       beat_cnt <= beat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small FIFO model on the read side.
module tb_fifo_stream_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  fifo_stream_reader_if #(.DATA_WIDTH(8)) bus ();

  fifo_stream_reader #(.DATA_WIDTH(8), .PKT_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // FIFO model: show-ahead data, popped on rd_en at the clock edge
  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       fifo_flush = 1'b0;

  assign bus.fifo_empty   = (rd_ptr == wr_ptr);
  assign bus.fifo_data_rd = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (fifo_flush)          rd_ptr <= wr_ptr;
    else if (bus.fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  task automatic push_words(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[5:0]] = first + 8'(i);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic test_reset();
    bus.m_ready = 1'b0;
    bus.clr     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_words(3, 8'h11);
    repeat (3) @(negedge clk);
    n_chk++; if (bus.level !== 2'd2) begin n_fail++; $display("FAIL reset_pre_level got=%0d exp=2", bus.level); end
    #1 rst = 1'b1;
    #1;
    n_chk++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
    n_chk++; if (bus.m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data got=%h exp=00", bus.m_data); end
    n_chk++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last got=%b exp=0", bus.m_last); end
    n_chk++; if (bus.level !== 2'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    n_chk++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b exp=0", bus.fifo_rd_en); end
    fifo_flush = 1'b1;
    @(negedge clk);
    fifo_flush = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bus.m_ready = 1'b1;
    push_words(1, 8'hA5);
    #1;
    n_chk++; if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_rd_en got=%b exp=1", bus.fifo_rd_en); end
    n_chk++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%b exp=0", bus.m_valid); end
    @(negedge clk);
    n_chk++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", bus.m_valid); end
    n_chk++; if (bus.m_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h exp=a5", bus.m_data); end
    n_chk++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL single_rd_en_drop got=%b exp=0", bus.fifo_rd_en); end
    @(negedge clk);
    n_chk++; if (bus.level !== 2'd0) begin n_fail++; $display("FAIL single_level_after got=%0d exp=0", bus.level); end
    n_chk++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_after got=%b exp=0", bus.m_valid); end
  endtask

  task automatic test_streaming();
    bus.m_ready = 1'b1;
    push_words(8, 8'h01);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_chk++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid beat=%0d got=%b exp=1", i, bus.m_valid); end
      n_chk++; if (bus.m_data !== 8'(i + 1)) begin n_fail++; $display("FAIL stream_data beat=%0d got=%h exp=%h", i, bus.m_data, 8'(i + 1)); end
      n_chk++; if (bus.level !== 2'd1) begin n_fail++; $display("FAIL stream_level beat=%0d got=%0d exp=1", i, bus.level); end
    end
    @(negedge clk);
    n_chk++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid got=%b exp=0", bus.m_valid); end
  endtask

  task automatic test_backpressure();
    int rd_cnt = 0;
    int got = 0;
    bus.m_ready = 1'b0;
    push_words(5, 8'h01);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.fifo_rd_en) rd_cnt++;
      if (i > 0) begin
        n_chk++; if (bus.m_data !== 8'h01) begin n_fail++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=01", i, bus.m_data); end
      end
      @(negedge clk);
    end
    n_chk++; if (rd_cnt !== 2) begin n_fail++; $display("FAIL bp_read_count got=%0d exp=2", rd_cnt); end
    n_chk++; if (bus.level !== 2'd2) begin n_fail++; $display("FAIL bp_level got=%0d exp=2", bus.level); end
    bus.m_ready = 1'b1;
    for (int c = 0; c < 30 && got < 5; c++) begin
      #1;
      if (bus.m_valid) begin
        n_chk++; if (bus.m_data !== 8'(got + 1)) begin n_fail++; $display("FAIL bp_order idx=%0d got=%h exp=%h", got, bus.m_data, 8'(got + 1)); end
        got++;
      end
      @(negedge clk);
    end
    n_chk++; if (got !== 5) begin n_fail++; $display("FAIL bp_drain_count got=%0d exp=5", got); end
    n_chk++; if (bus.level !== 2'd0) begin n_fail++; $display("FAIL bp_final_level got=%0d exp=0", bus.level); end
  endtask

  task automatic test_framing();
    logic [15:0] pat = 16'b1011_0110_1101_0111;
    logic [7:0]  last_mask = '0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;
    logic        exp_last;
    int          beats = 0;
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    push_words(8, 8'h40);
    for (int c = 0; c < 40 && beats < 8; c++) begin
      bus.m_ready = pat[c % 16];
      #1;
      exp_last = bus.m_valid && ((beats % 4) == 3);
      n_chk++; if (bus.m_last !== exp_last) begin n_fail++; $display("FAIL frame_last cyc=%0d got=%b exp=%b", c, bus.m_last, exp_last); end
      if (prev_stall) begin
        n_chk++; if (bus.m_data !== prev_data || bus.m_last !== prev_last) begin n_fail++; $display("FAIL frame_stall_hold cyc=%0d got=%h/%b exp=%h/%b", c, bus.m_data, bus.m_last, prev_data, prev_last); end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      if (bus.m_valid && bus.m_ready) begin
        n_chk++; if (bus.m_data !== 8'h40 + 8'(beats)) begin n_fail++; $display("FAIL frame_data beat=%0d got=%h exp=%h", beats, bus.m_data, 8'h40 + 8'(beats)); end
        if (bus.m_last) last_mask[beats] = 1'b1;
        beats++;
      end
      @(negedge clk);
    end
    n_chk++; if (beats !== 8) begin n_fail++; $display("FAIL frame_beats got=%0d exp=8", beats); end
    n_chk++; if (last_mask !== 8'b1000_1000) begin n_fail++; $display("FAIL frame_last_mask got=%b exp=10001000", last_mask); end
    bus.m_ready = 1'b1;
  endtask

  task automatic test_clr();
    bus.m_ready = 1'b1;
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    push_words(8, 8'h80);
    repeat (3) @(negedge clk);
    bus.clr = 1'b1;
    #1;
    n_chk++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL clr_rd_en got=%b exp=0", bus.fifo_rd_en); end
    n_chk++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h82) begin n_fail++; $display("FAIL clr_cycle_beat got=%b/%h exp=1/82", bus.m_valid, bus.m_data); end
    @(negedge clk);
    bus.clr = 1'b0;
    #1;
    n_chk++; if (bus.level !== 2'd0) begin n_fail++; $display("FAIL clr_level got=%0d exp=0", bus.level); end
    n_chk++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got=%b exp=0", bus.m_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h83 + 8'(k)) begin n_fail++; $display("FAIL clr_post_data k=%0d got=%b/%h exp=1/%h", k, bus.m_valid, bus.m_data, 8'h83 + 8'(k)); end
      n_chk++; if (bus.m_last !== (k == 3)) begin n_fail++; $display("FAIL clr_post_last k=%0d got=%b exp=%b", k, bus.m_last, (k == 3)); end
    end
    repeat (4) @(negedge clk);
    n_chk++; if (bus.level !== 2'd0) begin n_fail++; $display("FAIL clr_drain_level got=%0d exp=0", bus.level); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    bus.m_ready = 1'b0;
    bus.clr     = 1'b0;
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_framing();
    test_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
